// File: rtl/qla_prom_responder_pkg.sv
// Shared definitions for the QLA PROM responder (25AA-style SPI EEPROM target).
// Contents: opcode constants, status bit indices, bus FSM state encoding,
// pending-latch-op encoding and the block-protect decode helper.
package qla_prom_responder_pkg;

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;
  localparam int ST_BP0 = 2;
  localparam int ST_BP1 = 3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CMD      = 4'd1,
    S_ADDR_HI  = 4'd2,
    S_ADDR_LO  = 4'd3,
    S_DATA_IN  = 4'd4,
    S_DATA_OUT = 4'd5,
    S_STAT_OUT = 4'd6,
    S_STAT_IN  = 4'd7,
    S_IGNORE   = 4'd8,
    S_COMMIT   = 4'd9
  } state_e;

  // Latch operation applied when CS deasserts on a byte boundary.
  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_WREN = 2'd1,
    P_WRDI = 2'd2
  } pend_e;

  // top2 = two MSBs of the target address.
  function automatic logic bp_protects(input logic [1:0] bp, input logic [1:0] top2);
    case (bp)
      2'b01:   return (top2 == 2'b11);
      2'b10:   return top2[1];
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/qla_prom_responder_spi_sync_edge.sv
// 2-flop synchronizer followed by an edge detector.
// Ports: clk/reset (async high), d_i asynchronous pin,
//        rise_o / fall_o single-cycle pulses, 3 clk after the pin edge.
module qla_prom_responder_spi_sync_edge
  import qla_prom_responder_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // s_q[1:0] is the synchronizer, s_q[2] the previous synchronized value.
  logic [2:0] s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_q <= {3{RST_VAL}};
    else       s_q <= {s_q[1:0], d_i};
  end

  assign rise_o =  s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] &  s_q[2];

endmodule

// File: rtl/qla_prom_responder.sv
// SPI mode-0 target emulating a byte-wide 25AA-family serial EEPROM.
// Ports:
//   clk, reset            system clock, async active-high reset
//   prom_sclk/cs/mosi     oversampled SPI pins from the initiator
//   prom_miso, _oe        serial data out and its drive enable
//   bd_addr, bd_rdata     backdoor memory read, 1-cycle latency
//   status                {BP[1:0], WEL, WIP}
//   state_dbg             bus FSM state
module qla_prom_responder
  import qla_prom_responder_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int PAGE_W       = 4,
  parameter int WRITE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prom_sclk,
  input  logic              prom_cs,
  input  logic              prom_mosi,
  output logic              prom_miso,
  output logic              prom_miso_oe,
  input  logic [ADDR_W-1:0] bd_addr,
  output logic [7:0]        bd_rdata,
  output logic [7:0]        status,
  output logic [3:0]        state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PSZ   = 1 << PAGE_W;
  localparam int CW    = $clog2(WRITE_CYCLES) + 1;

  // Memory contents survive reset; power-up value is erased (0xFF).
  logic [7:0] mem  [DEPTH] = '{default: 8'hFF};
  logic [7:0] pbuf [PSZ];

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_q;

  qla_prom_responder_spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d_i(prom_sclk), .rise_o(sclk_rise), .fall_o(sclk_fall));
  qla_prom_responder_spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d_i(prom_cs), .rise_o(cs_rise), .fall_o(cs_fall));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_q <= 2'b00;
    else       mosi_q <= {mosi_q[0], prom_mosi};
  end

  state_e              state_q;
  pend_e               pend_q;
  logic [7:0]          op_q, hi_q, out_q;
  logic [6:0]          sh_q;
  logic [2:0]          bit_cnt_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [PAGE_W-1:0]   off_q;
  logic                data_seen_q, wel_q, wip_q, miso_q, oe_q, first_q;
  logic [1:0]          bp_q, bp_new_q;
  logic [PSZ-1:0]      vld_q;
  logic                cmt_act_q, cmt_wrsr_q;
  logic [CW-1:0]       cmt_cnt_q;
  logic [ADDR_W-PAGE_W-1:0] cmt_base_q;
  logic [7:0]          bd_rdata_q;

  logic [7:0]        byte_in, entry_byte, nxt_byte;
  logic              byte_done, cmt_done, mem_we;
  logic [ADDR_W-1:0] ptr_d, ptr_next, cmt_wa;
  logic [PAGE_W-1:0] cmt_idx;

  // mosi_q[1] is aligned with the synchronized sclk that produces sclk_rise.
  assign byte_in   = {sh_q, mosi_q[1]};
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  assign ptr_d     = ADDR_W'({hi_q, byte_in});
  assign ptr_next  = ptr_q + ADDR_W'(1);

  assign status     = {4'b0000, bp_q, wel_q, wip_q};
  assign entry_byte = (op_q == OP_READ) ? mem[ptr_d] : status;
  assign nxt_byte   = (state_q == S_DATA_OUT) ? mem[ptr_next] : status;

  assign cmt_done = cmt_act_q & (cmt_cnt_q == CW'(WRITE_CYCLES - 1));
  assign cmt_idx  = cmt_cnt_q[PAGE_W-1:0];
  assign cmt_wa   = {cmt_base_q, cmt_idx};
  assign mem_we   = cmt_act_q & ~cmt_wrsr_q & (cmt_cnt_q < CW'(PSZ)) & vld_q[cmt_idx] &
                    ~bp_protects(bp_q, cmt_wa[ADDR_W-1 -: 2]);

  always_ff @(posedge clk) begin
    if ((state_q == S_DATA_IN) && byte_done) pbuf[off_q] <= byte_in;
    if (mem_we) mem[cmt_wa] <= pbuf[cmt_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= P_NONE;
      op_q        <= 8'h00;
      hi_q        <= 8'h00;
      out_q       <= 8'h00;
      sh_q        <= 7'h00;
      bit_cnt_q   <= 3'd0;
      ptr_q       <= '0;
      off_q       <= '0;
      data_seen_q <= 1'b0;
      wel_q       <= 1'b0;
      wip_q       <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      first_q     <= 1'b0;
      bp_q        <= 2'b00;
      bp_new_q    <= 2'b00;
      vld_q       <= '0;
      cmt_act_q   <= 1'b0;
      cmt_wrsr_q  <= 1'b0;
      cmt_cnt_q   <= '0;
      cmt_base_q  <= '0;
      bd_rdata_q  <= 8'h00;
    end else begin
      bd_rdata_q <= mem[bd_addr];

      if (sclk_rise) begin
        sh_q      <= byte_in[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      // The fall right after entering an output phase keeps the MSB already
      // presented; a fall on a byte boundary loads the next byte.
      if (sclk_fall && oe_q) begin
        if (first_q) begin
          first_q <= 1'b0;
        end else if (bit_cnt_q == 3'd0) begin
          if (state_q == S_DATA_OUT) ptr_q <= ptr_next;
          miso_q <= nxt_byte[7];
          out_q  <= {nxt_byte[6:0], 1'b0};
        end else begin
          miso_q <= out_q[7];
          out_q  <= {out_q[6:0], 1'b0};
        end
      end

      if (cmt_act_q) begin
        if (cmt_done) begin
          cmt_act_q <= 1'b0;
          wip_q     <= 1'b0;
          wel_q     <= 1'b0;
          vld_q     <= '0;
        end else begin
          cmt_cnt_q <= cmt_cnt_q + CW'(1);
        end
      end

      case (state_q)
        S_IDLE: if (cs_fall) begin
          state_q   <= S_CMD;
          bit_cnt_q <= 3'd0;
        end
        S_CMD: if (byte_done) begin
          op_q        <= byte_in;
          pend_q      <= P_NONE;
          data_seen_q <= 1'b0;
          state_q     <= S_IGNORE;
          if (!wip_q || byte_in == OP_RDSR) begin
            case (byte_in)
              OP_WREN: pend_q <= P_WREN;
              OP_WRDI: pend_q <= P_WRDI;
              OP_RDSR: begin
                state_q <= S_STAT_OUT;
                oe_q    <= 1'b1;
                first_q <= 1'b1;
                miso_q  <= status[7];
                out_q   <= {status[6:0], 1'b0};
              end
              OP_WRSR:  if (wel_q) state_q <= S_STAT_IN;
              OP_READ:  state_q <= S_ADDR_HI;
              OP_WRITE: if (wel_q) begin
                state_q <= S_ADDR_HI;
                vld_q   <= '0;
              end
              default: ;
            endcase
          end
        end
        S_ADDR_HI: if (byte_done) begin
          hi_q    <= byte_in;
          state_q <= S_ADDR_LO;
        end
        S_ADDR_LO: if (byte_done) begin
          ptr_q <= ptr_d;
          off_q <= ptr_d[PAGE_W-1:0];
          if (op_q == OP_READ) begin
            state_q <= S_DATA_OUT;
            oe_q    <= 1'b1;
            first_q <= 1'b1;
            miso_q  <= entry_byte[7];
            out_q   <= {entry_byte[6:0], 1'b0};
          end else begin
            state_q <= S_DATA_IN;
          end
        end
        S_DATA_IN: if (byte_done) begin
          vld_q[off_q] <= 1'b1;
          off_q        <= off_q + PAGE_W'(1);
          data_seen_q  <= 1'b1;
        end
        S_STAT_IN: if (byte_done) begin
          bp_new_q    <= byte_in[ST_BP1:ST_BP0];
          data_seen_q <= 1'b1;
        end
        S_COMMIT: begin
          // The bus side may start a new transaction while the commit runs.
          if (cs_fall) begin
            state_q   <= S_CMD;
            bit_cnt_q <= 3'd0;
          end else if (cmt_done) begin
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase

      // CS deassert: commit or apply the latch op on a byte boundary,
      // otherwise abort with no side effects.
      if (cs_rise && state_q != S_IDLE && state_q != S_COMMIT) begin
        oe_q    <= 1'b0;
        first_q <= 1'b0;
        state_q <= S_IDLE;
        if (bit_cnt_q == 3'd0) begin
          if ((state_q == S_DATA_IN || state_q == S_STAT_IN) && data_seen_q) begin
            state_q    <= S_COMMIT;
            wip_q      <= 1'b1;
            cmt_act_q  <= 1'b1;
            cmt_cnt_q  <= '0;
            cmt_wrsr_q <= (state_q == S_STAT_IN);
            cmt_base_q <= ptr_q[ADDR_W-1:PAGE_W];
            if (state_q == S_STAT_IN) bp_q <= bp_new_q;
          end else if (state_q == S_IGNORE) begin
            if (pend_q == P_WREN) wel_q <= 1'b1;
            if (pend_q == P_WRDI) wel_q <= 1'b0;
          end
        end
      end
    end
  end

  assign prom_miso    = miso_q;
  assign prom_miso_oe = oe_q;
  assign bd_rdata     = bd_rdata_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_qla_prom_responder.sv
module tb_qla_prom_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prom_sclk = 1'b0;
  logic       prom_cs = 1'b1;
  logic       prom_mosi = 1'b0;
  logic       prom_miso, prom_miso_oe;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_rdata, status;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;

  qla_prom_responder dut (
    .clk(clk), .reset(reset),
    .prom_sclk(prom_sclk), .prom_cs(prom_cs), .prom_mosi(prom_mosi),
    .prom_miso(prom_miso), .prom_miso_oe(prom_miso_oe),
    .bd_addr(bd_addr), .bd_rdata(bd_rdata),
    .status(status), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sclk high/low 8 clk each; miso sampled just before each rise.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, input int nbits = 8);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      prom_mosi = tx[7-i];
      repeat (8) @(negedge clk);
      rx[7-i] = prom_miso;
      prom_sclk = 1'b1;
      repeat (8) @(negedge clk);
      prom_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    xfer(tx, rx);
  endtask

  task automatic cs_low();
    prom_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    prom_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Raise CS and count cycles with WIP set; also capture status on the first one.
  task automatic cs_high_commit(output int wip_cnt, output logic [7:0] first_stat);
    bit seen = 0;
    wip_cnt = 0;
    first_stat = 8'hxx;
    repeat (8) @(negedge clk);
    prom_cs = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (status[0]) begin
        if (!seen) first_stat = status;
        seen = 1;
        wip_cnt++;
      end else if (seen) break;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic bd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bd_addr = a;
    repeat (2) @(negedge clk);
    chk(tag, {8'h00, bd_rdata}, {8'h00, exp});
  endtask

  task automatic wren();
    cs_low(); send(8'h06); cs_high();
  endtask

  initial begin
    logic [7:0] rx;
    int         wc;
    logic [7:0] fs;

    repeat (3) @(negedge clk);
    chk("rst_miso", {15'h0, prom_miso}, 16'h0);
    chk("rst_oe", {15'h0, prom_miso_oe}, 16'h0);
    chk("rst_bd", {8'h0, bd_rdata}, 16'h0);
    chk("rst_status", {8'h0, status}, 16'h0);
    chk("rst_state", {12'h0, state_dbg}, 16'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    bd_chk("init_mem", 8'h10, 8'hFF);

    // WRITE without WREN is ignored
    cs_low(); send(8'h02); send(8'h00); send(8'h10); send(8'hA5); cs_high();
    repeat (80) @(negedge clk);
    bd_chk("nowel_mem", 8'h10, 8'hFF);
    cs_low(); send(8'h05); xfer(8'h00, rx); cs_high();
    chk("nowel_rdsr", {8'h0, rx}, 16'h00);

    // WREN + WRITE 0x0010 A5 5A
    wren();
    chk("wren_status", {8'h0, status}, 16'h02);
    cs_low(); send(8'h02); send(8'h00); send(8'h10); send(8'hA5); send(8'h5A);
    cs_high_commit(wc, fs);
    chk("wr_wip_cycles", wc[15:0], 16'd64);
    chk("wr_wip_status", {8'h0, fs}, 16'h03);
    bd_chk("wr_mem10", 8'h10, 8'hA5);
    bd_chk("wr_mem11", 8'h11, 8'h5A);
    chk("wr_wel_clear", {8'h0, status}, 16'h00);

    // 0x11..0x14 at 0xFE..0x01 (two pages), then READ across 0xFF->0x00
    wren();
    cs_low(); send(8'h02); send(8'h00); send(8'hFE); send(8'h11); send(8'h12);
    cs_high_commit(wc, fs);
    wren();
    cs_low(); send(8'h02); send(8'h00); send(8'h00); send(8'h13); send(8'h14);
    cs_high_commit(wc, fs);
    cs_low(); send(8'h03); send(8'h00); send(8'hFE);
    chk("rd_oe", {15'h0, prom_miso_oe}, 16'h1);
    xfer(8'h00, rx); chk("rd_b0", {8'h0, rx}, 16'h11);
    xfer(8'h00, rx); chk("rd_b1", {8'h0, rx}, 16'h12);
    xfer(8'h00, rx); chk("rd_b2", {8'h0, rx}, 16'h13);
    xfer(8'h00, rx); chk("rd_b3", {8'h0, rx}, 16'h14);
    cs_high();
    chk("rd_oe_off", {15'h0, prom_miso_oe}, 16'h0);

    // Page wrap within 0x00..0x0F
    wren();
    cs_low(); send(8'h02); send(8'h00); send(8'h0E); send(8'h01); send(8'h02); send(8'h03);
    cs_high_commit(wc, fs);
    bd_chk("pw_mem0e", 8'h0E, 8'h01);
    bd_chk("pw_mem0f", 8'h0F, 8'h02);
    bd_chk("pw_mem00", 8'h00, 8'h03);

    // Partial byte: 12 data bits, then CS high -> abort, WEL kept
    wren();
    cs_low(); send(8'h02); send(8'h00); send(8'h20); send(8'h77); xfer(8'h80, rx, 4);
    cs_high();
    repeat (80) @(negedge clk);
    chk("part_status", {8'h0, status}, 16'h02);
    chk("part_state", {12'h0, state_dbg}, 16'h0);
    bd_chk("part_mem", 8'h20, 8'hFF);

    // WRSR 0x0C (BP=11, WEL still set), then a protected WRITE
    cs_low(); send(8'h01); send(8'h0C);
    cs_high_commit(wc, fs);
    chk("wrsr_wip_cycles", wc[15:0], 16'd64);
    chk("wrsr_status", {8'h0, status}, 16'h0C);
    wren();
    cs_low(); send(8'h02); send(8'h00); send(8'h80); send(8'h99);
    cs_high_commit(wc, fs);
    chk("prot_wip_cycles", wc[15:0], 16'd64);
    chk("prot_wip_status", {8'h0, fs}, 16'h0F);
    bd_chk("prot_mem", 8'h80, 8'hFF);
    cs_low(); send(8'h05);
    xfer(8'h00, rx); chk("rdsr_b0", {8'h0, rx}, 16'h0C);
    xfer(8'h00, rx); chk("rdsr_b1", {8'h0, rx}, 16'h0C);
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
